cpu_bus_arb: RTL
================

CPU_BUS_ARB -- requirements
Module: cpu_bus_arb

Interface
REQ-001 SHALL have parameter NUM_M, default 3, number of bus masters (legal 2..8); index 0 is highest fixed priority.
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter DATA_W, default 8, data width.
REQ-004 SHALL have parameter RR_MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort (legal 1..65535).
REQ-006 SHALL have one clock and a synchronous, active-high reset: `clk  in  1  system clock` and `rst  in  1  synchronous active-high reset`.
REQ-007 SHALL have `m_req  in  NUM_M  per-master transaction request (level)`.
REQ-008 SHALL have `m_r_nw  in  NUM_M  per-master read(1)/write(0)`.
REQ-009 SHALL have `m_a  in  NUM_M*ADDR_W  per-master address, master i at bits [i*ADDR_W +: ADDR_W]`.
REQ-010 SHALL have `m_dout  in  NUM_M*DATA_W  per-master write data, same packing as m_a`.
REQ-011 SHALL have `m_lock  in  NUM_M  per-master bus lock (debugger break, sprite DMA burst)`.
REQ-012 SHALL have `s_rdy  in  1  memory controller completion strobe`.
REQ-013 SHALL have `s_din  in  DATA_W  memory controller read data`.
REQ-014 SHALL have `s_req  out  1  request to memory controller`.
REQ-015 SHALL have `s_r_nw  out  1`, `s_a  out  ADDR_W` and `s_dout  out  DATA_W`, all latched transaction fields.
REQ-016 SHALL have `grant  out  NUM_M  one-hot owner; all-zero when idle`.
REQ-017 SHALL have `m_ack  out  NUM_M  one-cycle completion pulse to owner`.
REQ-018 SHALL have `m_err  out  NUM_M  one-cycle timeout pulse to owner`.
REQ-019 SHALL have `m_din  out  DATA_W  registered read data, shared by all masters`.
REQ-020 SHALL have `m_stall  out  NUM_M  high for every master with m_req=1 that is not receiving m_ack/m_err this cycle`.

Function
REQ-021 SHALL implement a state machine with states IDLE, ISSUE and WAIT.
REQ-022 IDLE: when any m_req bit is 1, SHALL select a winner, register grant, capture m_r_nw/m_a/m_dout of the winner into s_* registers, and go to ISSUE the next cycle.
REQ-023 Fixed mode: the winner SHALL be the lowest requesting index.
REQ-024 Round-robin mode: the winner SHALL be the first requesting index at or after pointer rr_ptr, wrapping modulo NUM_M.
REQ-025 On every m_ack or m_err, rr_ptr SHALL become (owner+1) mod NUM_M, wrapping from NUM_M-1 to 0; rr_ptr SHALL be unchanged in fixed mode.
REQ-026 Lock: if the last owner holds m_lock=1 in IDLE, only that master SHALL be eligible; other requesters stall even if higher priority.
REQ-027 Lock: if the locked master has m_req=0 in IDLE, no grant SHALL issue and the bus stays idle.
REQ-028 ISSUE: s_req SHALL be 1 for exactly one cycle; the FSM SHALL then enter WAIT and clear the timeout counter.
REQ-029 WAIT: s_req SHALL be 0 and the s_a/s_r_nw/s_dout fields SHALL be held stable.
REQ-030 WAIT, s_rdy=1: SHALL register s_din into m_din only if s_r_nw=1, pulse m_ack[owner] in the next cycle, and return to IDLE.
REQ-031 WAIT, counter reaching TIMEOUT without s_rdy: SHALL pulse m_err[owner], leave m_din unchanged, and return to IDLE.
REQ-032 s_rdy and timeout in the same cycle: s_rdy SHALL win.
REQ-033 s_rdy sampled outside WAIT SHALL be ignored.
REQ-034 Minimum latency: m_req at cycle T (IDLE), s_req at T+1, s_rdy at T+2, m_ack and m_din valid at T+3.
REQ-035 Back-to-back: the IDLE cycle coincident with m_ack SHALL arbitrate, so throughput is one transaction per 3 cycles when s_rdy is immediate.
REQ-036 Once granted, the transaction SHALL be committed; m_req deassertion or field changes during ISSUE/WAIT SHALL be ignored.
REQ-037 grant SHALL stay asserted from ISSUE through the ack cycle.
REQ-038 m_din SHALL hold its value until the next successful read.

Reset
REQ-039 rst=1 at any clock edge, including mid-WAIT, SHALL force IDLE, s_req=0, s_r_nw=1, s_a=0, s_dout=0, grant=0, m_ack=0, m_err=0, m_din=0, rr_ptr=0, and the lock owner and timeout counter cleared.
REQ-040 A transaction aborted by reset SHALL produce no m_ack or m_err.
REQ-041 The first grant after reset SHALL occur no earlier than the cycle after rst falls.

Verification
REQ-042 Fixed mode, NUM_M=3, m_req=3'b110 at T, s_rdy at T+2: grant=3'b010 from T+1, m_ack=3'b010 at T+3, then master 2 served.
REQ-043 RR_MODE=1, m_req=3'b111 held, s_rdy immediate: grant sequence 0,1,2,0, each grant 3 cycles apart.
REQ-044 Read at address 0x8000 with s_din=0xA5: s_a=0x8000 and s_r_nw=1 during ISSUE; m_din=0xA5 on ack and held through a following write.
REQ-045 TIMEOUT=4, s_rdy never asserted: m_err[owner] pulses exactly once, 4 cycles after entering WAIT, and m_din is unchanged.
REQ-046 m_lock[1]=1 after master 1 completes, m_req=3'b011: master 0 stalls and master 1 is regranted until m_lock[1]=0.
REQ-047 rst pulsed mid-WAIT followed by a late s_rdy: no m_ack, all outputs at reset values, normal arbitration the cycle after rst falls.

Source files
------------

// File: rtl/cpu_bus_arb_if.sv
// Bus bundle that joins the CPU-side masters and the memory controller through the arbiter.
// The arbiter uses the master modport; the slave modport is the environment's side of the same bus.
interface cpu_bus_arb_if #(
   parameter int NUM_M  = 3,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [NUM_M-1:0]        m_req;
   logic [NUM_M-1:0]        m_r_nw;
   logic [NUM_M*ADDR_W-1:0] m_a;
   logic [NUM_M*DATA_W-1:0] m_dout;
   logic [NUM_M-1:0]        m_lock;
   logic                    s_rdy;
   logic [DATA_W-1:0]       s_din;
   logic                    s_req;
   logic                    s_r_nw;
   logic [ADDR_W-1:0]       s_a;
   logic [DATA_W-1:0]       s_dout;
   logic [NUM_M-1:0]        grant;
   logic [NUM_M-1:0]        m_ack;
   logic [NUM_M-1:0]        m_err;
   logic [DATA_W-1:0]       m_din;
   logic [NUM_M-1:0]        m_stall;

   modport master (
      input  m_req, m_r_nw, m_a, m_dout, m_lock, s_rdy, s_din,
      output s_req, s_r_nw, s_a, s_dout, grant, m_ack, m_err, m_din, m_stall
   );

   modport slave (
      output m_req, m_r_nw, m_a, m_dout, m_lock, s_rdy, s_din,
      input  s_req, s_r_nw, s_a, s_dout, grant, m_ack, m_err, m_din, m_stall
   );
endinterface

// File: rtl/cpu_bus_arb.sv
// Multi-master CPU bus arbiter: fixed or round-robin priority, bus lock, and a
// single outstanding transaction to the memory controller with a WAIT timeout.
module cpu_bus_arb #(
   parameter int NUM_M   = 3,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int RR_MODE = 0,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   cpu_bus_arb_if.master bus
);
   // state | meaning
   // IDLE  | arbitrate; the previous owner's ack/err pulse may be showing
   // ISSUE | s_req high for one cycle with the latched fields
   // WAIT  | fields held, waiting for s_rdy or the timeout
   localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int SW = IW + 1;
   localparam int TW = 16;
   localparam logic [NUM_M-1:0] ONE = {{(NUM_M-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [NUM_M-1:0]  r_grant;
   logic [NUM_M-1:0]  r_ack;
   logic [NUM_M-1:0]  r_err;
   logic [IW-1:0]     r_own;
   logic              r_own_vld;
   logic [IW-1:0]     r_ptr;
   logic              r_s_r_nw;
   logic [ADDR_W-1:0] r_s_a;
   logic [DATA_W-1:0] r_s_dout;
   logic [DATA_W-1:0] r_din;
   logic [TW-1:0]     r_tmr;

   logic [NUM_M-1:0]  w_elig;
   logic              w_lock;
   logic [SW-1:0]     w_sum;
   logic [IW-1:0]     w_idx;
   logic [IW-1:0]     w_win;
   logic              w_any;
   logic              w_s_req;
   logic              w_done;
   logic              w_tout;

   // A locking last owner shuts every other master out, even if it is not requesting.
   assign w_lock = r_own_vld & bus.m_lock[r_own];
   assign w_elig = w_lock ? (bus.m_req & (ONE << r_own)) : bus.m_req;

   // Scan from the highest offset down so the last hit is the first index at/after r_ptr.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      w_sum = '0;
      w_idx = '0;
      for (int k = NUM_M - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + SW'(k);
         if (w_sum >= SW'(NUM_M)) w_sum = w_sum - SW'(NUM_M);
         w_idx = w_sum[IW-1:0];
         if (w_elig[w_idx]) begin
            w_win = w_idx;
            w_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      w_s_req = 1'b0;
      w_done  = 1'b0;
      w_tout  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) w_next = ISSUE;
         end
         ISSUE: begin
            w_s_req = 1'b1;
            w_next  = WAIT;
         end
         WAIT: begin
            if (bus.s_rdy) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else if (r_tmr == '0) begin
               w_tout = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant   <= '0;
         r_ack     <= '0;
         r_err     <= '0;
         r_own     <= '0;
         r_own_vld <= 1'b0;
         r_ptr     <= '0;
         r_s_r_nw  <= 1'b1;
         r_s_a     <= '0;
         r_s_dout  <= '0;
         r_din     <= '0;
         r_tmr     <= '0;
      end else begin
         r_ack <= '0;
         r_err <= '0;
         // grant is only rewritten in IDLE, so it spans ISSUE through the ack cycle
         if (r_state == IDLE) begin
            r_grant <= w_any ? (ONE << w_win) : '0;
            if (w_any) begin
               r_own     <= w_win;
               r_own_vld <= 1'b1;
               r_s_r_nw  <= bus.m_r_nw[w_win];
               r_s_a     <= bus.m_a[w_win*ADDR_W +: ADDR_W];
               r_s_dout  <= bus.m_dout[w_win*DATA_W +: DATA_W];
            end
         end
         // Down-counter loaded on the way into WAIT; terminal count 0 is the abort cycle.
         if (r_state == ISSUE)
            r_tmr <= TW'(TIMEOUT - 1);
         else if (r_state == WAIT && r_tmr != '0)
            r_tmr <= r_tmr - 1'b1;
         if (w_done) begin
            r_ack <= r_grant;
            if (r_s_r_nw) r_din <= bus.s_din;
         end
         if (w_tout) r_err <= r_grant;
         if ((w_done || w_tout) && RR_MODE != 0)
            r_ptr <= (r_own == IW'(NUM_M - 1)) ? '0 : r_own + 1'b1;
      end
   end

   assign bus.s_req   = w_s_req;
   assign bus.s_r_nw  = r_s_r_nw;
   assign bus.s_a     = r_s_a;
   assign bus.s_dout  = r_s_dout;
   assign bus.grant   = r_grant;
   assign bus.m_ack   = r_ack;
   assign bus.m_err   = r_err;
   assign bus.m_din   = r_din;
   assign bus.m_stall = bus.m_req & ~(r_ack | r_err);
endmodule
